// File: rtl/pong_scoreboard.sv
// Two-player BCD score keeper for pong: detects the winning score and drives
// per-player 7-segment digit groups, blinking the winner's digits once the game ends.
module pong_scoreboard #(
  parameter int DIGITS    = 2,
  parameter int WIN_SCORE = 10,
  parameter int BLINK_DIV = 25_000_000,
  parameter int SEG_LOW   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  point_p1,
  input  logic                  point_p2,
  input  logic                  hold,
  output logic [4*DIGITS-1:0]   score_p1,
  output logic [4*DIGITS-1:0]   score_p2,
  output logic [7*DIGITS-1:0]   hex_p1,
  output logic [7*DIGITS-1:0]   hex_p2,
  output logic                  game_over,
  output logic [1:0]            winner
);

  localparam int SW    = 4 * DIGITS;
  localparam int HW    = 7 * DIGITS;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  function automatic int max_score(input int d);
    int m;
    m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [SW-1:0] to_bcd(input int v);
    logic [SW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Active-high segment pattern, bit0 = a .. bit6 = g; out-of-range codes blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Pattern for a zero score: "0" on digit 0, blank elsewhere.
  function automatic logic [HW-1:0] zero_hex();
    logic [HW-1:0] h;
    logic [6:0] s;
    h = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = (i == 0) ? 7'h3F : 7'h00;
      h[7*i +: 7] = (SEG_LOW != 0) ? ~s : s;
    end
    return h;
  endfunction

  localparam logic [SW-1:0]    WIN_BCD  = to_bcd(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [HW-1:0]    ZERO_HEX = zero_hex();

  generate
    if (DIGITS < 1 || DIGITS > 4 || WIN_SCORE < 0 || WIN_SCORE > max_score(DIGITS)
        || BLINK_DIV < 1) begin : g_param_check
      $error("pong_scoreboard: illegal DIGITS/WIN_SCORE/BLINK_DIV combination");
    end
  endgenerate

  typedef enum logic {PLAY, OVER} state_t;

  state_t           state_reg, state_next;
  logic [SW-1:0]    score_p1_reg, score_p1_next, score_p2_reg, score_p2_next;
  logic [SW-1:0]    inc_p1, inc_p2;
  logic [DIGITS-1:0] carry_p1, carry_p2;
  logic [1:0]       winner_reg, winner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;
  logic [HW-1:0]    hex_p1_reg, hex_p2_reg, hex_p1_next, hex_p2_next;
  logic [DIGITS-1:0] show_p1, show_p2;
  logic             acc_p1, acc_p2, reach_p1, reach_p2;
  logic             blank_p1, blank_p2;

  assign carry_p1[0] = 1'b1;
  assign carry_p2[0] = 1'b1;

  // Per-digit BCD incrementers with ripple carry; digit shown if it or any higher digit is nonzero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d1, d2;
      logic [6:0] seg1, seg2;
      assign d1 = score_p1_reg[4*gi +: 4];
      assign d2 = score_p2_reg[4*gi +: 4];
      assign inc_p1[4*gi +: 4] = carry_p1[gi] ? ((d1 == 4'd9) ? 4'd0 : d1 + 4'd1) : d1;
      assign inc_p2[4*gi +: 4] = carry_p2[gi] ? ((d2 == 4'd9) ? 4'd0 : d2 + 4'd1) : d2;
      if (gi < DIGITS - 1) begin : g_carry
        assign carry_p1[gi+1] = carry_p1[gi] & (d1 == 4'd9);
        assign carry_p2[gi+1] = carry_p2[gi] & (d2 == 4'd9);
      end
      if (gi == 0) begin : g_show0
        assign show_p1[gi] = 1'b1;
        assign show_p2[gi] = 1'b1;
      end else begin : g_shown
        assign show_p1[gi] = |score_p1_reg[SW-1:4*gi];
        assign show_p2[gi] = |score_p2_reg[SW-1:4*gi];
      end
      assign seg1 = (show_p1[gi] && !blank_p1) ? seg_code(d1) : 7'h00;
      assign seg2 = (show_p2[gi] && !blank_p2) ? seg_code(d2) : 7'h00;
      assign hex_p1_next[7*gi +: 7] = (SEG_LOW != 0) ? ~seg1 : seg1;
      assign hex_p2_next[7*gi +: 7] = (SEG_LOW != 0) ? ~seg2 : seg2;
    end
  endgenerate

  assign blank_p1 = (state_reg == OVER) && winner_reg[0] && !phase_reg;
  assign blank_p2 = (state_reg == OVER) && winner_reg[1] && !phase_reg;

  always_comb begin
    state_next    = state_reg;
    score_p1_next = score_p1_reg;
    score_p2_next = score_p2_reg;
    winner_next   = winner_reg;
    cnt_next      = cnt_reg;
    phase_next    = phase_reg;
    acc_p1        = point_p1 & ~hold;
    acc_p2        = point_p2 & ~hold;
    reach_p1      = 1'b0;
    reach_p2      = 1'b0;
    if (clear) begin
      state_next    = PLAY;
      score_p1_next = '0;
      score_p2_next = '0;
      winner_next   = 2'b00;
      cnt_next      = '0;
      phase_next    = 1'b1;
    end else begin
      case (state_reg)
        PLAY: begin
          cnt_next   = '0;
          phase_next = 1'b1;
          if (acc_p1) score_p1_next = inc_p1;
          if (acc_p2) score_p2_next = inc_p2;
          reach_p1 = (WIN_SCORE != 0) && acc_p1 && (inc_p1 == WIN_BCD);
          reach_p2 = (WIN_SCORE != 0) && acc_p2 && (inc_p2 == WIN_BCD);
          if (reach_p1 || reach_p2) begin
            state_next  = OVER;
            winner_next = {reach_p2, reach_p1};
          end
        end
        OVER: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            phase_next = ~phase_reg;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = PLAY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= PLAY;
      score_p1_reg <= '0;
      score_p2_reg <= '0;
      winner_reg   <= 2'b00;
      cnt_reg      <= '0;
      phase_reg    <= 1'b1;
      hex_p1_reg   <= ZERO_HEX;
      hex_p2_reg   <= ZERO_HEX;
    end else begin
      state_reg    <= state_next;
      score_p1_reg <= score_p1_next;
      score_p2_reg <= score_p2_next;
      winner_reg   <= winner_next;
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
      hex_p1_reg   <= clear ? ZERO_HEX : hex_p1_next;
      hex_p2_reg   <= clear ? ZERO_HEX : hex_p2_next;
    end
  end

  assign score_p1  = score_p1_reg;
  assign score_p2  = score_p2_reg;
  assign hex_p1    = hex_p1_reg;
  assign hex_p2    = hex_p2_reg;
  assign game_over = (state_reg == OVER);
  assign winner    = winner_reg;

endmodule
